// File: rtl/riscv_instr_loader.sv
// Host-side instruction loader: assembles BYTE_W chunks little-endian into WORD_W words
// and hands them to the fetch path through a first-word-fall-through FIFO.
module riscv_instr_loader #(
    parameter int WORD_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int DEPTH     = 4,
    parameter int EDGE_MODE = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ena,
    input  logic [BYTE_W-1:0]                    byte_in,
    input  logic                                 byte_stb,
    input  logic                                 flush,
    output logic [WORD_W-1:0]                    instr_data,
    output logic                                 instr_valid,
    input  logic                                 instr_ready,
    output logic [$clog2(DEPTH):0]               fill_level,
    output logic [$clog2(WORD_W/BYTE_W):0]       beat_cnt,
    output logic                                 full,
    output logic                                 overflow
);

    localparam int BEATS  = WORD_W / BYTE_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int BEAT_W = $clog2(BEATS) + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [FILL_W-1:0] fill_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic [WORD_W-1:0] asm_reg;
    logic [WORD_W-1:0] word_next;
    logic              stb_q_reg;
    logic              ovf_reg;

    logic cap;
    logic last_beat;
    logic push_req;
    logic push_ok;
    logic pop;
    logic is_empty;
    logic is_full;

    assign is_empty  = (fill_reg == '0);
    assign is_full   = (fill_reg == FILL_W'(DEPTH));
    assign cap       = ena & byte_stb & ((EDGE_MODE != 0) ? ~stb_q_reg : 1'b1);
    assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
    assign push_req  = cap & last_beat;
    assign pop       = ~is_empty & instr_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = push_req & (~is_full | pop);

    // Each lane takes the incoming chunk when it is the current beat, else keeps its byte.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
            assign word_next[gi*BYTE_W +: BYTE_W] =
                (beat_reg == BEAT_W'(gi)) ? byte_in : asm_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            beat_reg   <= '0;
            asm_reg    <= '0;
            stb_q_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            stb_q_reg <= byte_stb;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                fill_reg   <= '0;
                beat_reg   <= '0;
                ovf_reg    <= 1'b0;
            end else begin
                if (cap) begin
                    asm_reg  <= word_next;
                    beat_reg <= last_beat ? '0 : beat_reg + BEAT_W'(1);
                end
                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                if (push_ok && !pop) begin
                    fill_reg <= fill_reg + FILL_W'(1);
                end else if (pop && !push_ok) begin
                    fill_reg <= fill_reg - FILL_W'(1);
                end
                if (push_req && !push_ok) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) begin
            mem[wr_ptr_reg] <= word_next;
        end
    end

    // Head read is combinational so a word pushed into an empty FIFO shows on that same edge.
    assign instr_data  = is_empty ? '0 : mem[rd_ptr_reg];
    assign instr_valid = ~is_empty;
    assign fill_level  = fill_reg;
    assign beat_cnt    = beat_reg;
    assign full        = is_full;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Bench for riscv_instr_loader: queue-based reference model plus handshake scoreboard,
// directed scenarios followed by a randomized phase.
module tb_riscv_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  byte_in;
    logic        byte_stb;
    logic        flush;
    logic        instr_ready;

    logic [31:0] instr_data;
    logic        instr_valid;
    logic [2:0]  fill_level;
    logic [2:0]  beat_cnt;
    logic        full;
    logic        overflow;

    logic [31:0] d0_instr_data;
    logic        d0_instr_valid;
    logic [2:0]  d0_fill_level;
    logic [2:0]  d0_beat_cnt;
    logic        d0_full;
    logic        d0_overflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riscv_instr_loader #(.WORD_W(32), .BYTE_W(8), .DEPTH(4), .EDGE_MODE(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .byte_in(byte_in), .byte_stb(byte_stb),
        .flush(flush), .instr_data(instr_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fill_level(fill_level), .beat_cnt(beat_cnt),
        .full(full), .overflow(overflow)
    );

    riscv_instr_loader #(.WORD_W(32), .BYTE_W(8), .DEPTH(4), .EDGE_MODE(0)) dut_lvl (
        .clk(clk), .rst(rst), .ena(ena), .byte_in(byte_in), .byte_stb(byte_stb),
        .flush(flush), .instr_data(d0_instr_data), .instr_valid(d0_instr_valid),
        .instr_ready(instr_ready), .fill_level(d0_fill_level), .beat_cnt(d0_beat_cnt),
        .full(d0_full), .overflow(d0_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model (edge-mode DUT): stored words, pending chunks, strobe history, sticky flag.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_bytes[$];
    logic        m_stb_q;
    logic        m_ovf;
    logic [31:0] exp_q[$];
    bit          m_cap;
    bit          m_pop;
    logic [31:0] m_word;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_bytes.delete();
            exp_q.delete();
            m_stb_q = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_cap = ena && byte_stb && !m_stb_q;
            m_pop = (m_fifo.size() > 0) && instr_ready;
            if (flush) begin
                m_fifo.delete();
                m_bytes.delete();
                exp_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (m_pop) void'(m_fifo.pop_front());
                if (m_cap) begin
                    m_bytes.push_back(byte_in);
                    if (m_bytes.size() == 4) begin
                        m_word = 32'h0;
                        for (int i = 0; i < 4; i++) m_word = m_word | (32'(m_bytes[i]) << (8 * i));
                        m_bytes.delete();
                        if (m_fifo.size() < 4) begin
                            m_fifo.push_back(m_word);
                            exp_q.push_back(m_word);
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                end
            end
            m_stb_q = byte_stb;
        end
    end

    // Monitor: status against the model, and every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", 32'(instr_valid), 32'(m_fifo.size() > 0));
            check("data", instr_data, (m_fifo.size() > 0) ? m_fifo[0] : 32'h0);
            check("fill", 32'(fill_level), 32'(m_fifo.size()));
            check("beat", 32'(beat_cnt), 32'(m_bytes.size()));
            check("full", 32'(full), 32'(m_fifo.size() == 4));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (instr_valid && instr_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", instr_data, 32'hxxxx_xxxx);
                end else begin
                    check("pop_word", instr_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_in  = b;
        byte_stb = 1'b1;
        @(posedge clk); #1;
        byte_stb = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    logic [31:0] words[6];
    logic [31:0] clean_w;

    initial begin
        rst = 1'b1; ena = 1'b1; byte_in = 8'h0; byte_stb = 1'b0;
        flush = 1'b0; instr_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_data", instr_data, 32'h0);
        check("rst_fill", 32'(fill_level), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic assembly
        send_byte(8'h13, 10); send_byte(8'h00, 10); send_byte(8'h10, 10); send_byte(8'h00, 10);
        check("t1_data", instr_data, 32'h0010_0013);
        check("t1_valid", 32'(instr_valid), 32'h1);
        check("t1_fill", 32'(fill_level), 32'h1);

        // Held strobe: edge mode captures once, level mode captures every cycle
        pulse_flush();
        byte_stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            byte_in = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_stb = 1'b0;
        @(posedge clk); #1;
        check("t2_edge_beat", 32'(beat_cnt), 32'h1);
        check("t2_lvl_fill", 32'(d0_fill_level), 32'h1);
        check("t2_lvl_beat", 32'(d0_beat_cnt), 32'h1);

        // Overflow then in-order drain
        pulse_flush();
        for (int i = 0; i < 5; i++) begin
            words[i] = $urandom;
            send_word(words[i]);
        end
        check("t3_full", 32'(full), 32'h1);
        check("t3_ovf", 32'(overflow), 32'h1);
        check("t3_fill", 32'(fill_level), 32'h4);
        check("t3_head", instr_data, words[0]);
        instr_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        instr_ready = 1'b0;
        check("t3_empty", 32'(instr_valid), 32'h0);

        // Push and pop on the same edge while full
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            send_word(words[i]);
        end
        words[5] = $urandom;
        for (int i = 0; i < 3; i++) send_byte(words[5][8*i +: 8], 1);
        instr_ready = 1'b1;
        send_byte(words[5][31:24], 0);
        instr_ready = 1'b0;
        check("t4_fill", 32'(fill_level), 32'h4);
        check("t4_ovf", 32'(overflow), 32'h0);
        check("t4_head", instr_data, words[1]);
        instr_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        instr_ready = 1'b0;

        // Flush discards partial word and stored words
        pulse_flush();
        send_word($urandom); send_word($urandom);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        check("t5_fill_pre", 32'(fill_level), 32'h2);
        pulse_flush();
        check("t5_fill", 32'(fill_level), 32'h0);
        check("t5_beat", 32'(beat_cnt), 32'h0);
        check("t5_valid", 32'(instr_valid), 32'h0);
        clean_w = $urandom;
        send_word(clean_w);
        check("t5_word", instr_data, clean_w);

        // Asynchronous reset mid-word, then strobes with ena low
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("t6_data", instr_data, 32'h0);
        check("t6_valid", 32'(instr_valid), 32'h0);
        check("t6_fill", 32'(fill_level), 32'h0);
        check("t6_beat", 32'(beat_cnt), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ena = 1'b0;
        send_byte(8'h33, 1); send_byte(8'h44, 1); send_byte(8'h55, 1);
        check("t6_noena_beat", 32'(beat_cnt), 32'h0);
        check("t6_noena_fill", 32'(fill_level), 32'h0);
        ena = 1'b1;

        // Randomized phase
        for (int c = 0; c < 600; c++) begin
            byte_in     = 8'($urandom);
            byte_stb    = 1'($urandom_range(0, 1));
            ena         = ($urandom % 4) != 0;
            instr_ready = ($urandom % 3) == 0;
            flush       = ($urandom % 60) == 0;
            @(posedge clk); #1;
        end
        flush = 1'b0; byte_stb = 1'b0; instr_ready = 1'b0;
        @(posedge clk); #1;
        check("final_sb_level", 32'(fill_level), 32'(exp_q.size()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
